// File: rtl/sec_pkg.sv
// Shared definitions for the secure call-stack block.
//   OP_CS_*   : 3-bit operation encodings presented on i_op
//   FLT_*     : 4-bit fault cause codes reported on o_fault_code
//   cs_state_e: control FSM states (IDLE accepts ops, SCRUB zeroes a flushed stack)
package sec_pkg;

  localparam logic [2:0] OP_CS_NOP       = 3'd0;
  localparam logic [2:0] OP_CS_CALL      = 3'd1;
  localparam logic [2:0] OP_CS_RET       = 3'd2;
  localparam logic [2:0] OP_CS_JMP       = 3'd3;
  localparam logic [2:0] OP_CS_INT_ENTRY = 3'd4;
  localparam logic [2:0] OP_CS_LAND      = 3'd5;
  localparam logic [2:0] OP_CS_FLUSH     = 3'd6;

  localparam logic [3:0] FLT_NONE         = 4'd0;
  localparam logic [3:0] FLT_OVERFLOW     = 4'd1;
  localparam logic [3:0] FLT_UNDERFLOW    = 4'd2;
  localparam logic [3:0] FLT_INVALID_CALL = 4'd3;
  localparam logic [3:0] FLT_ILLEGAL_LAND = 4'd4;
  localparam logic [3:0] FLT_DOUBLE       = 4'd5;
  localparam logic [3:0] FLT_BAD_CTX      = 4'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } cs_state_e;

endpackage

// File: rtl/sec_stack_mem.sv
// Return-address storage shared by all contexts.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address {ctx, index}
//   i_wdata : data written
//   i_raddr : read address {ctx, index}
//   o_rdata : combinational read data
// The array has no reset; entries are only read after being written.
module sec_stack_mem #(
  parameter int ADDR_W = 16,
  parameter int NENT   = 32,
  parameter int MA_W   = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [MA_W-1:0]   i_waddr,
  input  logic [ADDR_W-1:0] i_wdata,
  input  logic [MA_W-1:0]   i_raddr,
  output logic [ADDR_W-1:0] o_rdata
);

  logic [ADDR_W-1:0] r_mem [NENT];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sec_call_stack.sv
// Hardware return-address stack with control-flow enforcement, one stack
// and one landing flag per hardware context.
//   clk, reset             : clock, asynchronous active-high reset
//   i_ctx_sel              : context the operation applies to
//   i_op_valid / o_op_ready: an op is accepted when both are high in a cycle
//   i_op, i_op_pc          : operation code and return address to push
//   o_ret_valid, o_ret_addr: registered pop result (o_ret_addr holds between pulses)
//   o_fault_valid/code/ctx : registered one-cycle fault report
//   o_sp_out               : combinational depth of the i_ctx_sel stack
//   o_land_pending_out     : combinational landing flag of i_ctx_sel
// Handshake: i_op_valid && o_op_ready accepts the op on that rising edge;
// o_op_ready is low only while a flushed stack is being scrubbed, and ops
// offered then are simply not taken.
module sec_call_stack
  import sec_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 16,
  parameter int NCTX    = 2,
  parameter int RESERVE = 2,
  localparam int CTX_W  = (NCTX > 1) ? $clog2(NCTX) : 1,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int SP_W   = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTX_W-1:0]  i_ctx_sel,
  input  logic              i_op_valid,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_op_pc,
  output logic              o_op_ready,
  output logic              o_ret_valid,
  output logic [ADDR_W-1:0] o_ret_addr,
  output logic              o_fault_valid,
  output logic [3:0]        o_fault_code,
  output logic [CTX_W-1:0]  o_fault_ctx,
  output logic [SP_W-1:0]   o_sp_out,
  output logic              o_land_pending_out
);

  localparam logic [SP_W-1:0]  SP_LIMIT = SP_W'(DEPTH - RESERVE);
  localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

  cs_state_e         r_state, w_next_state;
  logic [SP_W-1:0]   r_sp [NCTX];
  logic [NCTX-1:0]   r_land;
  logic [IDX_W-1:0]  r_scrub_idx;
  logic [CTX_W-1:0]  r_scrub_ctx;

  logic              w_ctx_ok, w_op_real, w_ready, w_land;
  logic [CTX_W-1:0]  w_ctx;
  logic [SP_W-1:0]   w_sp, w_sp_m1;
  logic [3:0]        w_fault;
  logic              w_push, w_pop, w_set_land, w_clr_land, w_flush;
  logic              w_we;
  logic [CTX_W+IDX_W-1:0] w_waddr, w_raddr;
  logic [ADDR_W-1:0] w_wdata, w_rdata;

  // An out-of-range context is steered to context 0 for all reads so no
  // array is indexed past its end; such ops only ever raise BAD_CTX.
  assign w_ctx_ok  = int'(i_ctx_sel) < NCTX;
  assign w_ctx     = w_ctx_ok ? i_ctx_sel : '0;
  assign w_sp      = r_sp[w_ctx];
  assign w_sp_m1   = w_sp - 1'b1;
  assign w_land    = r_land[w_ctx];
  // Undefined encoding 7 behaves like NOP.
  assign w_op_real = (i_op != OP_CS_NOP) && (i_op <= OP_CS_FLUSH);

  assign o_op_ready         = w_ready;
  assign o_sp_out           = w_ctx_ok ? w_sp : '0;
  assign o_land_pending_out = w_ctx_ok & w_land;

  always_comb begin
    w_next_state = r_state;
    w_ready      = (r_state == IDLE);
    w_fault      = FLT_NONE;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_set_land   = 1'b0;
    w_clr_land   = 1'b0;
    w_flush      = 1'b0;
    if (w_ready && i_op_valid && w_op_real) begin
      if (!w_ctx_ok) begin
        w_fault = FLT_BAD_CTX;
      end else if (w_land && (i_op != OP_CS_LAND)) begin
        w_fault    = FLT_INVALID_CALL;
        w_clr_land = 1'b1;
      end else begin
        case (i_op)
          OP_CS_CALL: begin
            // The top RESERVE slots stay free for interrupt entry.
            if (w_sp >= SP_LIMIT) w_fault = FLT_OVERFLOW;
            else begin
              w_push     = 1'b1;
              w_set_land = 1'b1;
            end
          end
          OP_CS_JMP: w_set_land = 1'b1;
          OP_CS_INT_ENTRY: begin
            if (w_sp == SP_FULL) w_fault = FLT_DOUBLE;
            else                 w_push  = 1'b1;
          end
          OP_CS_RET: begin
            if (w_sp == '0) w_fault = FLT_UNDERFLOW;
            else            w_pop   = 1'b1;
          end
          OP_CS_LAND: begin
            if (!w_land) w_fault    = FLT_ILLEGAL_LAND;
            else         w_clr_land = 1'b1;
          end
          OP_CS_FLUSH: begin
            w_flush    = 1'b1;
            w_clr_land = 1'b1;
          end
          default: ;
        endcase
      end
    end
    case (r_state)
      IDLE:    if (w_flush) w_next_state = SCRUB;
      SCRUB:   if (r_scrub_idx == IDX_LAST) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Scrub writes take the single write port; no ops are accepted meanwhile.
  always_comb begin
    if (r_state == SCRUB) begin
      w_we    = 1'b1;
      w_waddr = {r_scrub_ctx, r_scrub_idx};
      w_wdata = '0;
    end else begin
      w_we    = w_push;
      w_waddr = {w_ctx, w_sp[IDX_W-1:0]};
      w_wdata = i_op_pc;
    end
  end

  assign w_raddr = {w_ctx, w_sp_m1[IDX_W-1:0]};

  sec_stack_mem #(
    .ADDR_W (ADDR_W),
    .NENT   (NCTX * DEPTH),
    .MA_W   (CTX_W + IDX_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCTX; c++) r_sp[c] <= '0;
      r_land      <= '0;
      r_scrub_idx <= '0;
      r_scrub_ctx <= '0;
    end else begin
      if (w_push)       r_sp[w_ctx] <= w_sp + 1'b1;
      else if (w_pop)   r_sp[w_ctx] <= w_sp_m1;
      else if (w_flush) r_sp[w_ctx] <= '0;
      if (w_set_land)      r_land[w_ctx] <= 1'b1;
      else if (w_clr_land) r_land[w_ctx] <= 1'b0;
      // The counter wraps to 0 on its last entry, ready for the next flush.
      if (w_flush) begin
        r_scrub_idx <= '0;
        r_scrub_ctx <= w_ctx;
      end else if (r_state == SCRUB) begin
        r_scrub_idx <= r_scrub_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_ret_valid   <= 1'b0;
      o_ret_addr    <= '0;
      o_fault_valid <= 1'b0;
      o_fault_code  <= FLT_NONE;
      o_fault_ctx   <= '0;
    end else begin
      o_ret_valid   <= w_pop;
      if (w_pop) o_ret_addr <= w_rdata;
      o_fault_valid <= (w_fault != FLT_NONE);
      o_fault_code  <= w_fault;
      if (w_fault != FLT_NONE) o_fault_ctx <= i_ctx_sel;
    end
  end

endmodule

// File: tb/tb_sec_call_stack.sv
module tb_sec_call_stack;
  import sec_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // DUT A: DEPTH=4, RESERVE=1, NCTX=2
  logic        a_ctx = 1'b0, a_valid = 1'b0;
  logic [2:0]  a_op = 3'd0;
  logic [15:0] a_pc = 16'h0;
  logic        a_ready, a_rv, a_fv, a_fctx, a_land;
  logic [15:0] a_ra;
  logic [3:0]  a_fc;
  logic [2:0]  a_sp;

  // DUT B: same geometry but NCTX=3 so an out-of-range context is reachable
  logic [1:0]  b_ctx = 2'd0;
  logic        b_valid = 1'b0;
  logic [2:0]  b_op = 3'd0;
  logic [15:0] b_pc = 16'h0;
  logic        b_ready, b_rv, b_fv, b_land;
  logic [15:0] b_ra;
  logic [3:0]  b_fc;
  logic [1:0]  b_fctx;
  logic [2:0]  b_sp;

  sec_call_stack #(.ADDR_W(16), .DEPTH(4), .NCTX(2), .RESERVE(1)) dut_a (
    .clk(clk), .reset(reset), .i_ctx_sel(a_ctx), .i_op_valid(a_valid),
    .i_op(a_op), .i_op_pc(a_pc), .o_op_ready(a_ready), .o_ret_valid(a_rv),
    .o_ret_addr(a_ra), .o_fault_valid(a_fv), .o_fault_code(a_fc),
    .o_fault_ctx(a_fctx), .o_sp_out(a_sp), .o_land_pending_out(a_land)
  );

  sec_call_stack #(.ADDR_W(16), .DEPTH(4), .NCTX(3), .RESERVE(1)) dut_b (
    .clk(clk), .reset(reset), .i_ctx_sel(b_ctx), .i_op_valid(b_valid),
    .i_op(b_op), .i_op_pc(b_pc), .o_op_ready(b_ready), .o_ret_valid(b_rv),
    .o_ret_addr(b_ra), .o_fault_valid(b_fv), .o_fault_code(b_fc),
    .o_fault_ctx(b_fctx), .o_sp_out(b_sp), .o_land_pending_out(b_land)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: called at posedge+1, return at posedge+1 after the accepting edge,
  // where the registered results of that op are visible.
  task automatic op_a(input logic c, input logic [2:0] o, input logic [15:0] pc);
    a_ctx = c; a_op = o; a_pc = pc; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_op = OP_CS_NOP;
  endtask

  task automatic op_b(input logic [1:0] c, input logic [2:0] o, input logic [15:0] pc);
    b_ctx = c; b_op = o; b_pc = pc; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0; b_op = OP_CS_NOP;
  endtask

  task automatic exp_a(input string tag, input logic rv, input logic [15:0] ra,
                       input logic fv, input logic [3:0] fc, input logic [2:0] sp,
                       input logic land);
    chk({tag, ".ret_valid"}, a_rv, rv);
    chk({tag, ".ret_addr"}, a_ra, ra);
    chk({tag, ".fault_valid"}, a_fv, fv);
    if (fv) chk({tag, ".fault_code"}, a_fc, fc);
    chk({tag, ".sp"}, a_sp, sp);
    chk({tag, ".land"}, a_land, land);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    chk("rst.ready", a_ready, 1);
    exp_a("rst", 0, 16'h0, 0, FLT_NONE, 3'd0, 0);
    chk("rst.fault_code", a_fc, 0);
    chk("rst.fault_ctx", a_fctx, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // nested CALL/LAND then RETs in LIFO order
    op_a(0, OP_CS_CALL, 16'h0100); exp_a("t1.call1", 0, 16'h0, 0, 0, 3'd1, 1);
    op_a(0, OP_CS_LAND, 16'h0);    exp_a("t1.land1", 0, 16'h0, 0, 0, 3'd1, 0);
    op_a(0, OP_CS_CALL, 16'h0200); exp_a("t1.call2", 0, 16'h0, 0, 0, 3'd2, 1);
    op_a(0, OP_CS_LAND, 16'h0);    exp_a("t1.land2", 0, 16'h0, 0, 0, 3'd2, 0);
    exp_q.push_back(32'h0200); exp_q.push_back(32'h0100);
    op_a(0, OP_CS_RET, 16'h0);     exp_a("t1.ret1", 1, 16'(exp_q.pop_front()), 0, 0, 3'd1, 0);
    op_a(0, OP_CS_RET, 16'h0);     exp_a("t1.ret2", 1, 16'(exp_q.pop_front()), 0, 0, 3'd0, 0);

    // fill to DEPTH-RESERVE, overflow, then reserved interrupt slot
    for (int i = 1; i <= 3; i++) begin
      op_a(0, OP_CS_CALL, 16'(i));
      op_a(0, OP_CS_LAND, 16'h0);
    end
    chk("t2.sp3", a_sp, 3);
    op_a(0, OP_CS_CALL, 16'h0004); exp_a("t2.ovf", 0, 16'h0100, 1, FLT_OVERFLOW, 3'd3, 0);
    chk("t2.ovf.ctx", a_fctx, 0);
    op_a(0, OP_CS_INT_ENTRY, 16'h0300); exp_a("t2.int1", 0, 16'h0100, 0, 0, 3'd4, 0);
    op_a(0, OP_CS_INT_ENTRY, 16'h0301); exp_a("t2.int2", 0, 16'h0100, 1, FLT_DOUBLE, 3'd4, 0);
    op_a(0, OP_CS_RET, 16'h0);          exp_a("t2.ret", 1, 16'h0300, 0, 0, 3'd3, 0);

    // underflow on empty ctx1
    op_a(1, OP_CS_RET, 16'h0); exp_a("t3.unf", 0, 16'h0300, 1, FLT_UNDERFLOW, 3'd0, 0);
    chk("t3.unf.ctx", a_fctx, 1);

    // landing enforcement on ctx1
    op_a(1, OP_CS_JMP, 16'h0);     exp_a("t4.jmp", 0, 16'h0300, 0, 0, 3'd0, 1);
    op_a(1, OP_CS_NOP, 16'h0);     exp_a("t4.nop", 0, 16'h0300, 0, 0, 3'd0, 1);
    op_a(1, OP_CS_CALL, 16'h0444); exp_a("t4.inv", 0, 16'h0300, 1, FLT_INVALID_CALL, 3'd0, 0);
    op_a(1, OP_CS_LAND, 16'h0);    exp_a("t4.ill", 0, 16'h0300, 1, FLT_ILLEGAL_LAND, 3'd0, 0);
    a_ctx = 0; #1;
    chk("t4.ctx0_sp", a_sp, 3);

    // FLUSH blocks for DEPTH cycles and leaves the other context intact
    op_a(0, OP_CS_INT_ENTRY, 16'h0AAA); chk("t5.sp0", a_sp, 4);
    op_a(1, OP_CS_INT_ENTRY, 16'h0BBB); chk("t5.sp1", a_sp, 1);
    op_a(0, OP_CS_FLUSH, 16'h0);        exp_a("t5.flush", 0, 16'h0300, 0, 0, 3'd0, 0);
    // offer a CALL on ctx1 while blocked; it must not be taken
    a_ctx = 1; a_op = OP_CS_CALL; a_pc = 16'h0DDD; a_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_ready) break;
      cnt++;
      @(posedge clk); #1;
    end
    a_valid = 1'b0; a_op = OP_CS_NOP;
    chk("t5.block_cycles", cnt, 4);
    chk("t5.ctx1_sp_kept", a_sp, 1);
    op_a(1, OP_CS_RET, 16'h0); exp_a("t5.ret1", 1, 16'h0BBB, 0, 0, 3'd0, 0);
    op_a(0, OP_CS_RET, 16'h0); exp_a("t5.ret0", 0, 16'h0BBB, 1, FLT_UNDERFLOW, 3'd0, 0);

    // reset in the middle of a scrub
    op_a(1, OP_CS_RET, 16'h0);          chk("t6.fctx", a_fctx, 1);
    op_a(1, OP_CS_INT_ENTRY, 16'h0CCC); chk("t6.sp1", a_sp, 1);
    op_a(0, OP_CS_CALL, 16'h0555);
    op_a(0, OP_CS_LAND, 16'h0);
    op_a(0, OP_CS_FLUSH, 16'h0);
    @(posedge clk); #1;
    chk("t6.scrub_ready", a_ready, 0);
    reset = 1'b1; #1;
    a_ctx = 1; #1;
    chk("t6.async.ready", a_ready, 1);
    exp_a("t6.async", 0, 16'h0, 0, 0, 3'd0, 0);
    chk("t6.async.fctx", a_fctx, 0);
    @(posedge clk); #1;
    chk("t6.next.ready", a_ready, 1);
    reset = 1'b0;
    op_a(0, OP_CS_INT_ENTRY, 16'h0777); exp_a("t6.post.int", 0, 16'h0, 0, 0, 3'd1, 0);
    op_a(0, OP_CS_RET, 16'h0);          exp_a("t6.post.ret", 1, 16'h0777, 0, 0, 3'd0, 0);

    // out-of-range context on the NCTX=3 build
    op_b(2, OP_CS_INT_ENTRY, 16'h0D00); chk("t7.sp2", b_sp, 1);
    op_b(3, OP_CS_RET, 16'h0);
    chk("t7.badret.fv", b_fv, 1); chk("t7.badret.fc", b_fc, FLT_BAD_CTX);
    chk("t7.badret.ctx", b_fctx, 3); chk("t7.badret.rv", b_rv, 0);
    op_b(3, OP_CS_CALL, 16'h0E00);
    chk("t7.badcall.fc", b_fc, FLT_BAD_CTX); chk("t7.badcall.fv", b_fv, 1);
    b_ctx = 0; #1;
    chk("t7.ctx0.sp", b_sp, 0); chk("t7.ctx0.land", b_land, 0);
    op_b(2, OP_CS_RET, 16'h0);
    chk("t7.ret.rv", b_rv, 1); chk("t7.ret.ra", b_ra, 16'h0D00);
    chk("t7.ret.fv", b_fv, 0); chk("t7.ret.sp", b_sp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
